// File: rtl/sdram_port_arbiter.sv
// Shares one Avalon-MM SDRAM master between a high-priority read-only port 0 and a read/write port 1.
// Commands and read data pass through with zero added latency; a port stalls on SDRAM wait or when MAX_PENDING reads are outstanding.
module sdram_port_arbiter #(
  parameter int MAX_PENDING = 31,
  parameter int PEND_W      = 5
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic        iP0_RD_EN,
  input  logic [24:0] iP0_RD_ADDR,
  output logic        oP0_WAIT_REQUEST,
  output logic [15:0] oP0_RD_DATA,
  output logic        oP0_RD_DATAVALID,
  input  logic        iP1_RD_EN,
  input  logic        iP1_WR_EN,
  input  logic [24:0] iP1_ADDR,
  input  logic [15:0] iP1_WR_DATA,
  output logic        oP1_WAIT_REQUEST,
  output logic [15:0] oP1_RD_DATA,
  output logic        oP1_RD_DATAVALID,
  output logic [24:0] oSDRAM_ADDR,
  output logic        oSDRAM_RD,
  output logic        oSDRAM_WR,
  output logic [15:0] oSDRAM_WDATA,
  input  logic        iSDRAM_WAIT_REQUEST,
  input  logic [15:0] iSDRAM_RDATA,
  input  logic        iSDRAM_RDATAVALID,
  output logic [1:0]  oGRANT,
  output logic        oERR_SPURIOUS
);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, DRAIN} state_t;

  typedef struct packed {
    logic [24:0] addr;
    logic [15:0] wdata;
    logic        rd;
    logic        wr;
  } cmd_t;

  localparam logic [PEND_W-1:0] PEND_FULL = PEND_W'(MAX_PENDING);

  state_t            state;
  logic [PEND_W-1:0] pend;
  logic              owner;
  logic              err;
  logic [1:0]        grant;

  cmd_t cmd;
  logic p0_wait;
  logic p1_wait;
  logic p1_cmd;
  logic full;
  logic pend_zero;
  logic rd_acc;
  logic preempt;

  assign p1_cmd    = iP1_RD_EN | iP1_WR_EN;
  assign full      = (pend == PEND_FULL);
  assign pend_zero = (pend == '0);

  // Only the granted port reaches the SDRAM; reads are masked once the pending count is full.
  always_comb begin
    cmd.addr  = iP1_ADDR;
    cmd.wdata = iP1_WR_DATA;
    cmd.rd    = 1'b0;
    cmd.wr    = 1'b0;
    p0_wait   = 1'b1;
    p1_wait   = 1'b1;
    case (state)
      GRANT0: begin
        cmd.addr = iP0_RD_ADDR;
        cmd.rd   = iP0_RD_EN & ~full;
        p0_wait  = iSDRAM_WAIT_REQUEST | (full & iP0_RD_EN);
      end
      GRANT1: begin
        cmd.rd  = iP1_RD_EN & ~full;
        cmd.wr  = iP1_WR_EN;
        p1_wait = iSDRAM_WAIT_REQUEST | (full & iP1_RD_EN);
      end
      default: ;
    endcase
  end

  assign rd_acc = cmd.rd & ~iSDRAM_WAIT_REQUEST;

  // A port 1 command already stalled by the SDRAM must be accepted before port 0 can take over.
  assign preempt = iP0_RD_EN & ~(p1_cmd & iSDRAM_WAIT_REQUEST);

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state <= IDLE;
      pend  <= '0;
      owner <= 1'b0;
      err   <= 1'b0;
      grant <= 2'b00;
    end else begin
      if (rd_acc && !iSDRAM_RDATAVALID) begin
        pend <= pend + PEND_W'(1);
      end else if (!rd_acc && iSDRAM_RDATAVALID && !pend_zero) begin
        pend <= pend - PEND_W'(1);
      end
      if (iSDRAM_RDATAVALID && pend_zero) begin
        err <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (iP0_RD_EN) begin
            state <= GRANT0;
            owner <= 1'b0;
            grant <= 2'b01;
          end else if (p1_cmd) begin
            state <= GRANT1;
            owner <= 1'b1;
            grant <= 2'b10;
          end
        end
        GRANT0: begin
          if (!iP0_RD_EN) begin
            state <= pend_zero ? IDLE : DRAIN;
            grant <= 2'b00;
          end
        end
        GRANT1: begin
          if (!p1_cmd) begin
            state <= pend_zero ? IDLE : DRAIN;
            grant <= 2'b00;
          end else if (preempt) begin
            state <= (pend_zero && !rd_acc) ? IDLE : DRAIN;
            grant <= 2'b00;
          end
        end
        DRAIN: begin
          if (pend_zero) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          grant <= 2'b00;
        end
      endcase
    end
  end

  assign oSDRAM_ADDR      = cmd.addr;
  assign oSDRAM_WDATA     = cmd.wdata;
  assign oSDRAM_RD        = cmd.rd;
  assign oSDRAM_WR        = cmd.wr;
  assign oP0_WAIT_REQUEST = p0_wait;
  assign oP1_WAIT_REQUEST = p1_wait;

  // Every outstanding read belongs to the same port, so one owner bit steers all returns.
  assign oP0_RD_DATA      = iSDRAM_RDATA;
  assign oP1_RD_DATA      = iSDRAM_RDATA;
  assign oP0_RD_DATAVALID = iSDRAM_RDATAVALID & ~owner;
  assign oP1_RD_DATAVALID = iSDRAM_RDATAVALID & owner;

  assign oGRANT        = grant;
  assign oERR_SPURIOUS = err;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Random-stimulus bench for sdram_port_arbiter: SDRAM responder, transaction-level reference model, per-cycle compare.
module tb_sdram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p0_rd;
  logic [24:0] p0_addr;
  logic        p0_wait;
  logic [15:0] p0_data;
  logic        p0_dv;
  logic        p1_rd;
  logic        p1_wr;
  logic [24:0] p1_addr;
  logic [15:0] p1_wdata;
  logic        p1_wait;
  logic [15:0] p1_data;
  logic        p1_dv;
  logic [24:0] sd_addr;
  logic        sd_rd;
  logic        sd_wr;
  logic [15:0] sd_wdata;
  logic        sd_wait;
  logic [15:0] sd_rdata;
  logic        sd_rdv;
  logic [1:0]  grant;
  logic        err;

  always #5 clk = ~clk;

  sdram_port_arbiter #(.MAX_PENDING(31), .PEND_W(5)) dut (
    .iCLK(clk), .iRST_N(rst_n),
    .iP0_RD_EN(p0_rd), .iP0_RD_ADDR(p0_addr), .oP0_WAIT_REQUEST(p0_wait),
    .oP0_RD_DATA(p0_data), .oP0_RD_DATAVALID(p0_dv),
    .iP1_RD_EN(p1_rd), .iP1_WR_EN(p1_wr), .iP1_ADDR(p1_addr), .iP1_WR_DATA(p1_wdata),
    .oP1_WAIT_REQUEST(p1_wait), .oP1_RD_DATA(p1_data), .oP1_RD_DATAVALID(p1_dv),
    .oSDRAM_ADDR(sd_addr), .oSDRAM_RD(sd_rd), .oSDRAM_WR(sd_wr), .oSDRAM_WDATA(sd_wdata),
    .iSDRAM_WAIT_REQUEST(sd_wait), .iSDRAM_RDATA(sd_rdata), .iSDRAM_RDATAVALID(sd_rdv),
    .oGRANT(grant), .oERR_SPURIOUS(err)
  );

  typedef struct {
    int          t;
    logic [15:0] d;
  } ret_t;

  typedef struct {
    logic        owner;
    logic [15:0] data;
  } tag_t;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int lat = 7;
  int unsigned wait_pct = 0;
  bit force_wait = 0;
  bit hold_ret = 0;
  int cnt_acc_rd = 0;
  int cnt_wr = 0;
  int cnt_p0dv = 0;
  int cnt_p1dv = 0;

  ret_t sq[$];

  // Reference model: who holds the port, whether we are draining, and the owner/data of every read in flight.
  int   m_holder = -1;
  bit   m_drain = 0;
  bit   m_owner = 0;
  bit   m_err = 0;
  tag_t tags[$];

  function automatic logic [15:0] dat_of(input logic [24:0] a);
    return a[15:0] ^ 16'h5A3C ^ {7'd0, a[24:16]};
  endfunction

  function void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // SDRAM responder: random stall, fixed-latency in-order returns.
  always @(posedge clk) begin
    #1;
    cyc++;
    sd_wait = force_wait || ($urandom_range(99) < wait_pct);
    if (rst_n && !hold_ret && sq.size() > 0 && sq[0].t <= cyc) begin
      sd_rdv   = 1'b1;
      sd_rdata = sq[0].d;
      void'(sq.pop_front());
    end else begin
      sd_rdv   = 1'b0;
      sd_rdata = 16'($urandom);
    end
  end

  int          c_p;
  logic        c_full, c_erd, c_ewr, c_ep0w, c_ep1w, c_acc, c_p1c, c_o;
  logic [24:0] c_eaddr;
  logic [1:0]  c_eg;
  logic [15:0] c_d;
  ret_t        c_r;
  tag_t        c_t;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_holder = -1;
      m_drain  = 0;
      m_owner  = 0;
      m_err    = 0;
      tags.delete();
    end
    c_p    = tags.size();
    c_full = (c_p == 31);
    c_eg   = (m_holder == 0) ? 2'b01 : (m_holder == 1) ? 2'b10 : 2'b00;
    c_erd  = 0;
    c_ewr  = 0;
    c_ep0w = 1;
    c_ep1w = 1;
    c_eaddr = p1_addr;
    if (m_holder == 0) begin
      c_erd   = p0_rd && !c_full;
      c_eaddr = p0_addr;
      c_ep0w  = sd_wait || (c_full && p0_rd);
    end else if (m_holder == 1) begin
      c_erd  = p1_rd && !c_full;
      c_ewr  = p1_wr;
      c_ep1w = sd_wait || (c_full && p1_rd);
    end
    chk("grant", grant, c_eg);
    chk("sdram_rd", sd_rd, c_erd);
    chk("sdram_wr", sd_wr, c_ewr);
    chk("p0_wait", p0_wait, c_ep0w);
    chk("p1_wait", p1_wait, c_ep1w);
    if (c_erd || c_ewr) chk("sdram_addr", sd_addr, c_eaddr);
    if (c_ewr) chk("sdram_wdata", sd_wdata, p1_wdata);
    if (sd_rdv) begin
      c_o = (c_p > 0) ? tags[0].owner : m_owner;
      c_d = (c_p > 0) ? tags[0].data : sd_rdata;
      chk("p0_dv", p0_dv, !c_o);
      chk("p1_dv", p1_dv, c_o);
      chk("rd_data", c_o ? p1_data : p0_data, c_d);
    end else begin
      chk("p0_dv_idle", p0_dv, 0);
      chk("p1_dv_idle", p1_dv, 0);
    end
    chk("err", err, m_err);

    cnt_p0dv   += int'(p0_dv);
    cnt_p1dv   += int'(p1_dv);
    cnt_acc_rd += int'(sd_rd && !sd_wait);
    cnt_wr     += int'(sd_wr && !sd_wait);
    if (sd_rd && !sd_wait) begin
      c_r.t = cyc + lat;
      c_r.d = dat_of(sd_addr);
      sq.push_back(c_r);
    end

    if (rst_n) begin
      c_acc = c_erd && !sd_wait;
      c_p1c = p1_rd || p1_wr;
      if (sd_rdv && c_p == 0) m_err = 1;
      if (sd_rdv && c_p > 0) void'(tags.pop_front());
      if (c_acc && !(sd_rdv && c_p == 0)) begin
        c_t.owner = (m_holder == 1);
        c_t.data  = dat_of(c_eaddr);
        tags.push_back(c_t);
      end
      if (m_drain) begin
        if (c_p == 0) m_drain = 0;
      end else if (m_holder == -1) begin
        if (p0_rd) begin
          m_holder = 0;
          m_owner  = 0;
        end else if (c_p1c) begin
          m_holder = 1;
          m_owner  = 1;
        end
      end else if (m_holder == 0) begin
        if (!p0_rd) begin
          m_holder = -1;
          m_drain  = (c_p != 0);
        end
      end else begin
        if (!c_p1c) begin
          m_holder = -1;
          m_drain  = (c_p != 0);
        end else if (p0_rd && !sd_wait) begin
          m_holder = -1;
          m_drain  = !(c_p == 0 && !c_acc);
        end
      end
    end
  end

  task automatic wait_free(input bit port);
    int k = 0;
    @(negedge clk);
    while ((port ? p1_wait : p0_wait) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk(port ? "p1_accept_timeout" : "p0_accept_timeout", (k >= 3000), 0);
  endtask

  task automatic p0_reads(input int n, input logic [24:0] base);
    @(posedge clk); #1;
    p0_rd = 1'b1;
    for (int i = 0; i < n; i++) begin
      p0_addr = base + 25'(i);
      wait_free(1'b0);
      @(posedge clk); #1;
    end
    p0_rd = 1'b0;
  endtask

  task automatic p1_ops(input int n, input int unsigned wr_pct, input logic [24:0] base);
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      p1_wr    = ($urandom_range(99) < wr_pct);
      p1_rd    = !p1_wr;
      p1_addr  = base + 25'(i);
      p1_wdata = 16'($urandom);
      wait_free(1'b1);
      @(posedge clk); #1;
    end
    p1_rd = 1'b0;
    p1_wr = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    @(negedge clk);
    while ((grant != 2'b00 || tags.size() != 0 || sq.size() != 0) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk("idle_timeout", (k >= 3000), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic clr_cnt();
    cnt_acc_rd = 0;
    cnt_wr     = 0;
    cnt_p0dv   = 0;
    cnt_p1dv   = 0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_grant"}, grant, 2'b00);
    chk({tag, "_rd"}, sd_rd, 0);
    chk({tag, "_wr"}, sd_wr, 0);
    chk({tag, "_p0_wait"}, p0_wait, 1);
    chk({tag, "_p1_wait"}, p1_wait, 1);
    chk({tag, "_p0_dv"}, p0_dv, 0);
    chk({tag, "_p1_dv"}, p1_dv, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst_n = 0; p0_rd = 0; p0_addr = '0; p1_rd = 0; p1_wr = 0; p1_addr = '0; p1_wdata = '0;
    sd_wait = 0; sd_rdata = '0; sd_rdv = 0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("por");
    @(posedge clk); #1;
    rst_n = 1;

    // Port 0 line read.
    clr_cnt(); lat = 7; wait_pct = 30;
    p0_reads(512, 25'h010000);
    wait_idle();
    chk("line_acc", cnt_acc_rd, 512);
    chk("line_p0_dv", cnt_p0dv, 512);
    chk("line_p1_dv", cnt_p1dv, 0);

    // Simultaneous request.
    clr_cnt(); wait_pct = 20;
    fork
      p0_reads(6, 25'h020000);
      p1_ops(6, 50, 25'h030000);
      begin
        @(posedge clk); @(posedge clk); @(negedge clk);
        chk("simul_grant", grant, 2'b01);
      end
    join
    wait_idle();

    // Preemption while port 1 is stalled.
    clr_cnt(); wait_pct = 0; lat = 10;
    fork
      p1_ops(8, 0, 25'h040000);
      begin
        k = 0;
        while (cnt_acc_rd < 4 && k < 500) begin
          @(posedge clk);
          k++;
        end
        force_wait = 1;
        fork
          p0_reads(2, 25'h050000);
          begin
            repeat (4) @(posedge clk);
            force_wait = 0;
          end
        join
      end
      begin
        int j = 0;
        @(negedge clk);
        while (grant != 2'b01 && j < 2000) begin
          @(negedge clk);
          j++;
        end
        chk("preempt_p1_dv_before_grant0", cnt_p1dv, 5);
      end
    join
    wait_idle();

    // Pending-count saturation.
    clr_cnt(); wait_pct = 0; lat = 7; hold_ret = 1;
    fork
      p0_reads(40, 25'h060000);
      begin
        repeat (41) @(posedge clk);
        @(negedge clk);
        chk("sat_acc", cnt_acc_rd, 31);
        chk("sat_wait", p0_wait, 1);
        hold_ret = 0;
        @(posedge clk); #2;
        hold_ret = 1;
        @(posedge clk);
        chk("sat_ret_cycle_acc", cnt_acc_rd, 31);
        @(posedge clk);
        chk("sat_one_slot", cnt_acc_rd, 32);
        @(posedge clk);
        chk("sat_full_again", cnt_acc_rd, 32);
        hold_ret = 0;
      end
    join
    wait_idle();

    // Port 1 back-to-back writes.
    clr_cnt(); wait_pct = 0;
    p1_ops(16, 100, 25'h070000);
    @(posedge clk); @(negedge clk);
    chk("wr_release_grant", grant, 2'b00);
    wait_idle();
    chk("wr_count", cnt_wr, 16);
    chk("wr_no_reads", cnt_acc_rd, 0);

    // Mixed random traffic.
    for (int it = 0; it < 8; it++) begin
      wait_pct = $urandom_range(50);
      lat = $urandom_range(12, 3);
      fork
        p0_reads($urandom_range(20, 1), 25'($urandom));
        begin
          repeat ($urandom_range(10)) @(posedge clk);
          p1_ops($urandom_range(20, 1), 40, 25'($urandom));
        end
      join
      wait_idle();
    end

    // Reset mid-GRANT1 with three reads outstanding.
    clr_cnt(); wait_pct = 0; lat = 12;
    @(posedge clk); #1;
    p1_rd = 1; p1_addr = 25'h080000;
    k = 0;
    while (cnt_acc_rd < 3 && k < 500) begin
      @(posedge clk);
      k++;
    end
    #1;
    rst_n = 0;
    p1_rd = 0;
    @(negedge clk);
    chk_reset_outputs("mid");
    clr_cnt();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("late_err", err, 1);
    chk("late_p0_dv", cnt_p0dv, 3);
    chk("late_p1_dv", cnt_p1dv, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
